// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package if_id_pkg;

  // Default program-counter width for the shared entry type.
  localparam int FETCH_PC_W = 32;

  // sll $0,$0,0: the decoder reads this as a legal NOP that raises no exception.
  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  // One fetched instruction as it travels from fetch to decode.
  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           ins;
    logic                  adel;
  } fetch_entry_t;

  // A misaligned fetch has no meaningful instruction word, so it is stored as a NOP.
  // ID raises AdEL from the adel flag instead of from the decode result.
  function automatic logic [31:0] store_ins(input logic [31:0] ins, input logic adel);
    return adel ? NOP_INS : ins;
  endfunction

endpackage

// File: rtl/if_id_queue.sv
// First-word-fall-through instruction buffer between fetch and ID decode.
// The head entry is presented combinationally. A flush discards every
// entry, and any push made in the same cycle is dropped as well.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_ins,
  input  logic                     in_adel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_ins,
  output logic                     out_adel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage has no reset; only the pointers and occupancy define what is valid.
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [31:0]     ins_mem  [DEPTH];
  logic            adel_mem [DEPTH];

  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg,  count_next;

  logic push;
  logic pop;

  // Ready and valid come from registered occupancy only, so out_ready has no path to in_ready.
  assign in_ready  = (count_reg != FULL_COUNT);
  assign out_valid = (count_reg != '0);

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Present the head entry, or a NOP with zero PC and flag while empty.
  assign out_pc   = out_valid ? pc_mem[rd_ptr_reg]   : '0;
  assign out_ins  = out_valid ? ins_mem[rd_ptr_reg]  : NOP_INS;
  assign out_adel = out_valid ? adel_mem[rd_ptr_reg] : 1'b0;
  assign count    = count_reg;

  // Write the fetched entry at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= in_pc;
      ins_mem[wr_ptr_reg]  <= store_ins(in_ins, in_adel);
      adel_mem[wr_ptr_reg] <= in_adel;
    end
  end

  // Compute the next pointers and occupancy. Flush takes priority over push and pop.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  // Register the pointers and occupancy. Reset empties the queue at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed pushes, pops, flush and reset.
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_ins = '0;
  logic        in_adel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_adel;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  fetch_entry_t sb[$];

  if_id_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins), .in_adel(in_adel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .out_adel(out_adel), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every real pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h ins %h, expected no entry at %0t", out_pc, out_ins, $time);
      end else begin
        fetch_entry_t e;
        e = sb.pop_front();
        check("pop_pc", 64'(out_pc), 64'(e.pc));
        check("pop_ins", 64'(out_ins), 64'(e.ins));
        check("pop_adel", 64'(out_adel), 64'(e.adel));
        $display("pop  pc=%h ins=%h adel=%0b", out_pc, out_ins, out_adel);
      end
    end
  end

  // One clock cycle: drive at posedge+1, update the model, check state after the next edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic adel, input logic rdy, input logic fl);
    bit do_push, do_pop;
    fetch_entry_t e;
    in_valid = v; in_pc = pc; in_ins = ins; in_adel = adel; out_ready = rdy; flush = fl;
    do_push = v && (model_count != DEPTH) && !fl;
    do_pop  = rdy && (model_count != 0) && !fl;
    if (fl) begin
      model_count = 0;
    end else begin
      if (do_push) begin
        e.pc = pc; e.ins = adel ? 32'h0 : ins; e.adel = adel;
        sb.push_back(e);
        $display("push pc=%h ins=%h adel=%0b", pc, ins, adel);
      end
      model_count = model_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_adel = 1'b0;
    check("count", 64'(count), 64'(model_count));
    check("in_ready", 64'(in_ready), 64'(model_count != DEPTH));
    check("out_valid", 64'(out_valid), 64'(model_count != 0));
    if (model_count == 0) begin
      check("empty_ins", 64'(out_ins), 64'h0);
      check("empty_pc", 64'(out_pc), 64'h0);
      check("empty_adel", 64'(out_adel), 64'h0);
    end else if (sb.size() != 0) begin
      check("head_pc", 64'(out_pc), 64'(sb[0].pc));
      check("head_ins", 64'(out_ins), 64'(sb[0].ins));
      check("head_adel", 64'(out_adel), 64'(sb[0].adel));
    end
  endtask

  logic [9:0] mix_v = 10'b1011011101;
  logic [9:0] mix_r = 10'b1110101011;

  initial begin
    // Reset state
    #12;
    check("rst_count", 64'(count), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_ins", 64'(out_ins), 64'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // 1: single push, visible next cycle
    step(1, 32'hBFC0_0000, 32'h2408_0001, 0, 0, 0);
    check("t1_ins", 64'(out_ins), 64'h2408_0001);
    check("t1_count", 64'(count), 64'h1);
    step(0, 0, 0, 0, 1, 0);

    // 2: fill, refuse when full (with and without pop), drain in order
    for (int i = 0; i < 4; i++)
      step(1, 32'hBFC0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 0, 0, 0);
    check("t2_full_ready", 64'(in_ready), 64'h0);
    step(1, 32'hBFC0_0010, 32'h1000_0004, 0, 0, 0);
    check("t2_head_kept", 64'(out_pc), 64'hBFC0_0000);
    step(1, 32'hBFC0_0014, 32'h1000_0005, 0, 1, 0);
    check("t2_full_pop_count", 64'(count), 64'h3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    check("t2_drained_ins", 64'(out_ins), 64'h0);

    // 3: simultaneous push/pop at count=2, then mixed traffic across pointer wrap
    step(1, 32'h8000_0000, 32'hA000_0000, 0, 0, 0);
    step(1, 32'h8000_0004, 32'hA000_0001, 0, 0, 0);
    step(1, 32'h8000_0008, 32'hA000_0002, 0, 1, 0);
    check("t3_pushpop_count", 64'(count), 64'h2);
    for (int i = 0; i < 10; i++)
      step(mix_v[i], 32'h8000_0100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 0, mix_r[i], 0);
    while (model_count != 0) step(0, 0, 0, 0, 1, 0);

    // 4: flush with push and pop at count=3; flushed entry must never appear
    for (int i = 0; i < 3; i++)
      step(1, 32'h9000_0000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 0, 0, 0);
    step(1, 32'h9000_00F0, 32'hDEAD_BEEF, 0, 1, 1);
    check("t4_count", 64'(count), 64'h0);
    check("t4_in_ready", 64'(in_ready), 64'h1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // 5: address-error fetch stores a NOP with the flag set
    step(1, 32'hBFC0_0002, 32'hFFFF_FFFF, 1, 0, 0);
    check("t5_adel", 64'(out_adel), 64'h1);
    check("t5_ins", 64'(out_ins), 64'h0);
    check("t5_pc", 64'(out_pc), 64'hBFC0_0002);
    step(0, 0, 0, 0, 1, 0);

    // 6: asynchronous reset between edges with count=2
    step(1, 32'hA000_0000, 32'h1111_1111, 0, 0, 0);
    step(1, 32'hA000_0004, 32'h2222_2222, 0, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_count", 64'(count), 64'h0);
    check("t6_valid", 64'(out_valid), 64'h0);
    check("t6_in_ready", 64'(in_ready), 64'h1);
    sb.delete();
    model_count = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    step(1, 32'hA000_0100, 32'h3333_3333, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
